// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Central stall/flush sequencer for the 5-stage pipeline. It drives the PC
// and pipeline-register write enables and the bubble/flush controls, and
// resolves three kinds of hazard:
//   - load-use hazards between the load in EX and the instruction in ID
//   - taken-branch flushes of IF/ID
//   - multi-cycle data-memory accesses, through a RUN/MEM_WAIT handshake FSM
// It also keeps a saturating count of stall cycles.
//
// Ports:
//   clk_i, rst_n_i       clock, asynchronous active-low reset
//   ifid_rs1_i/rs2_i     source registers of the instruction in ID
//   idex_memread_i       the instruction in EX is a load
//   idex_rd_i            destination register of the instruction in EX
//   branch_taken_i       a branch resolved taken in ID this cycle
//   exmem_memop_i        the instruction in MEM is a load or store
//   dmem_ack_i           the data memory completed the access this cycle
//   dmem_req_o           data memory request
//   pc_write_o, ifid_write_o, idex_write_o, exmem_write_o   write enables
//   ifid_flush_o         IF/ID loads a NOP
//   idex_bubble_o        ID/EX loads zeroed control
//   memwb_bubble_o       MEM/WB captures RegWrite=0, MemtoReg=0
//   stall_cnt_o          saturating count of stalled cycles
module pipeline_hazard_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [4:0]       ifid_rs1_i,
  input  logic [4:0]       ifid_rs2_i,
  input  logic             idex_memread_i,
  input  logic [4:0]       idex_rd_i,
  input  logic             branch_taken_i,
  input  logic             exmem_memop_i,
  input  logic             dmem_ack_i,
  output logic             dmem_req_o,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_write_o,
  output logic             idex_bubble_o,
  output logic             exmem_write_o,
  output logic             memwb_bubble_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_stall;
  logic             load_use;

  // Hazard detection
  always_comb begin
    mem_stall = 1'b0;
    unique case (state_q)
      RUN:      mem_stall = exmem_memop_i & ~dmem_ack_i;
      MEM_WAIT: mem_stall = ~dmem_ack_i;
      default:  mem_stall = 1'b0;
    endcase

    // x0 is hard-wired to zero, so a load into x0 never creates a hazard.
    load_use = idex_memread_i && (idex_rd_i != 5'd0) &&
               ((idex_rd_i == ifid_rs1_i) || (idex_rd_i == ifid_rs2_i));
  end

  // Memory handshake FSM: next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:      if (exmem_memop_i && !dmem_ack_i) state_d = MEM_WAIT;
      MEM_WAIT: if (dmem_ack_i)                   state_d = RUN;
      default:  state_d = RUN;
    endcase
  end

  // Output decode. Priority: reset, then memory stall, then load-use, then
  // branch flush. A branch seen during any stall is not flushed here; ID
  // holds, so the branch is re-evaluated once the stall releases.
  always_comb begin
    dmem_req_o     = (state_q == MEM_WAIT) ? 1'b1 : exmem_memop_i;
    pc_write_o     = 1'b1;
    ifid_write_o   = 1'b1;
    ifid_flush_o   = 1'b0;
    idex_write_o   = 1'b1;
    idex_bubble_o  = 1'b0;
    exmem_write_o  = 1'b1;
    memwb_bubble_o = 1'b0;

    if (!rst_n_i) begin
      dmem_req_o     = 1'b0;
      pc_write_o     = 1'b0;
      ifid_write_o   = 1'b0;
      idex_write_o   = 1'b0;
      exmem_write_o  = 1'b0;
      idex_bubble_o  = 1'b1;
      memwb_bubble_o = 1'b1;
    end else if (mem_stall) begin
      pc_write_o     = 1'b0;
      ifid_write_o   = 1'b0;
      idex_write_o   = 1'b0;
      exmem_write_o  = 1'b0;
      memwb_bubble_o = 1'b1;
    end else if (load_use) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      idex_bubble_o = 1'b1;
    end else if (branch_taken_i) begin
      ifid_flush_o = 1'b1;
    end
  end

  // Saturating stall-cycle counter
  always_comb begin
    cnt_d = cnt_q;
    if ((mem_stall || load_use) && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign stall_cnt_o = cnt_q;

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage pipeline. Sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC, and drives their write enables and bubble/flush controls. Resolves load-use hazards, taken-branch flushes and multi-cycle data-memory accesses with a two-state memory handshake FSM. Keeps a saturating stall-cycle performance counter.

## Interface
- CNT_W, 16, width of the stall-cycle counter

- clk_i  in  1  clock; all state updates on the rising edge
- rst_n_i  in  1  reset, asynchronous, active-low
- ifid_rs1_i  in  5  rs1 address of the instruction in ID
- ifid_rs2_i  in  5  rs2 address of the instruction in ID
- idex_memread_i  in  1  instruction in EX is a load
- idex_rd_i  in  5  destination register of the instruction in EX
- branch_taken_i  in  1  branch resolved taken in ID this cycle
- exmem_memop_i  in  1  instruction in MEM is a load or store
- dmem_ack_i  in  1  data memory has completed the access; read data valid this cycle
- dmem_req_o  out  1  data memory access request
- pc_write_o  out  1  PC update enable
- ifid_write_o  out  1  IF/ID register write enable
- ifid_flush_o  out  1  IF/ID loads a NOP
- idex_write_o  out  1  ID/EX register write enable
- idex_bubble_o  out  1  ID/EX loads zeroed control (RegWrite, MemRead, MemWrite = 0)
- exmem_write_o  out  1  EX/MEM register write enable
- memwb_bubble_o  out  1  MEM/WB captures RegWrite=0, MemtoReg=0
- stall_cnt_o  out  CNT_W  saturating count of cycles with any stall

## Operation
- FSM states: RUN, MEM_WAIT. Reset state RUN.
- mem_stall (combinational): (RUN and exmem_memop_i and not dmem_ack_i) or (MEM_WAIT and not dmem_ack_i).
- dmem_req_o = exmem_memop_i in RUN; 1 in MEM_WAIT.
- Transitions: RUN -> MEM_WAIT when exmem_memop_i and not dmem_ack_i; RUN stays RUN on zero-wait ack; MEM_WAIT -> RUN on dmem_ack_i; otherwise hold.
- mem_stall = 1: pc_write_o, ifid_write_o, idex_write_o, exmem_write_o = 0; memwb_bubble_o = 1; idex_bubble_o = 0; ifid_flush_o = 0. Memory stall dominates all other conditions.
- load_use (combinational): idex_memread_i and idex_rd_i != 0 and (idex_rd_i == ifid_rs1_i or idex_rd_i == ifid_rs2_i).
- load_use and not mem_stall: pc_write_o = 0, ifid_write_o = 0, idex_bubble_o = 1; idex/exmem writes enabled; ifid_flush_o = 0 (branch is re-evaluated next cycle).
- branch_taken_i, no stall: ifid_flush_o = 1; all write enables 1.
- No condition: all write enables 1, bubbles/flush 0.
- stall_cnt_o increments by 1 each cycle mem_stall or load_use is 1; saturates at all-ones, no wrap.
- While rst_n_i low: state RUN, stall_cnt_o = 0, all *_write_o = 0, dmem_req_o = 0, memwb_bubble_o = 1, idex_bubble_o = 1, ifid_flush_o = 0.

## Timing
- All control outputs are combinational from inputs and state; they act on the same clock edge.
- Zero-wait memory (ack in request cycle): no stall, no state change.
- N-cycle memory (ack N cycles after first request cycle): N stall cycles; release on the ack cycle, when MEM/WB captures the read data and the pipeline advances at that edge.
- Ack in MEM_WAIT returns to RUN; next cycle's exmem_memop_i refers to the following instruction, issuing a new request if set.
- dmem_ack_i in RUN without exmem_memop_i is ignored.
- Reset assertion mid-access: FSM returns to RUN immediately; the outstanding request is dropped.

## Test plan
- Load x5 in EX, ID reads x5 as rs2, no memop in MEM -> one cycle: pc_write_o=0, ifid_write_o=0, idex_bubble_o=1; stall_cnt_o 0 -> 1.
- Load x0 in EX, ID rs1=0 -> no stall, all enables 1.
- Memop in MEM, ack 3 cycles later -> dmem_req_o=1 for 4 cycles; stall 3 cycles with memwb_bubble_o=1; state MEM_WAIT for cycles 2-4; stall_cnt_o = 3.
- Memop with same-cycle ack, back-to-back memops for 4 cycles -> no stall, state stays RUN, dmem_req_o=1 each cycle.
- branch_taken_i during memory stall -> ifid_flush_o=0; after release with branch_taken_i still 1 -> ifid_flush_o=1 for one cycle.
- Drive 2^CNT_W+5 load-use cycles -> stall_cnt_o holds at all-ones. Then pulse rst_n_i low mid-MEM_WAIT -> counter 0, state RUN, dmem_req_o=0 asynchronously.
